// File: rtl/instr_issue.sv
// rtl/instr_issue.sv - fetch/issue sequencer: fetches one instruction, holds its fields until accepted, then steps the pc.
// Optional FETCH_STALL_CNT_EN adds a saturating stall_cnt output counting FETCH cycles without imem_ack.
module instr_issue (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [15:0] imm16,
    output logic        issue_valid,
    input  logic        issue_ready,
    input  logic        jump,
    input  logic        branch,
    input  logic        zero,
    output logic [31:0] pc,
    output logic        halted
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [5:0] OPC_HALT = 6'h3F;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4;
    logic [31:0] br_off;
    logic        accept;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= 32'h0000_0000;
            instr_q <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign pc4    = pc_q + 32'd4;
    assign br_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    assign accept = (state_q == ISSUE) && issue_ready;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_data;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (accept) begin
                    // A halt instruction freezes the pc at its own address.
                    if (instr_q[31:26] == OPC_HALT) begin
                        state_d = HALT;
                    end else begin
                        state_d = FETCH;
                        if (jump) begin
                            pc_d = {pc4[31:28], instr_q[25:0], 2'b00};
                        end else if (branch && zero) begin
                            pc_d = pc4 + br_off;
                        end else begin
                            pc_d = pc4;
                        end
                    end
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign imem_req    = (state_q == FETCH);
    assign imem_addr   = pc_q;
    assign issue_valid = (state_q == ISSUE);
    assign halted      = (state_q == HALT);
    assign pc          = pc_q;

    assign opcode = instr_q[31:26];
    assign rs     = instr_q[25:21];
    assign rt     = instr_q[20:16];
    assign rd     = instr_q[15:11];
    assign imm16  = instr_q[15:0];
    assign funct  = instr_q[5:0];

`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= 16'h0000;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == FETCH) && !imem_ack && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
